// File: rtl/dmem_req_ctrl_if.sv
// SRAM-like data bus between the memory-stage request controller and the data memory.
// The controller is the master side; the memory or interconnect is the slave side.
interface dmem_req_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_req_ctrl.sv
// Memory-stage data request controller: one outstanding SRAM-like access at a time.
// Optional macro DMEM_RDATA_BYPASS_EN forwards data_rdata and releases busy in the completion cycle.
module dmem_req_ctrl (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m_req,
  input  logic                   m_wr,
  input  logic [1:0]             m_size,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  input  logic                   m_cancel,
  input  logic                   m_stall,
  output logic [31:0]            m_rdata,
  output logic                   busy,
  dmem_req_ctrl_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  state_t      done_next_s;
  logic        busy_done_s;
  logic        accept_s;
  logic        complete_s;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_q;

`ifdef DMEM_RDATA_BYPASS_EN
  assign done_next_s = m_stall ? DONE : IDLE;
  assign busy_done_s = 1'b0;
`else
  assign done_next_s = DONE;
  assign busy_done_s = 1'b1;
`endif

  // Bus fields come only from the captured copy so they stay stable while addr_ok is low.
  assign bus.data_req   = (state_r == REQ);
  assign bus.data_wr    = wr_r;
  assign bus.data_size  = size_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wdata = wdata_r;

  // Next-state, acceptance, completion and stall request.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    busy       = 1'b0;
    case (state_r)
      IDLE: begin
        if (m_req && !m_cancel) begin
          accept_s = 1'b1;
          busy     = 1'b1;
          state_s  = REQ;
        end else begin
          state_s  = IDLE;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            complete_s = 1'b1;
            busy       = busy_done_s;
            state_s    = done_next_s;
          end else begin
            state_s    = WAIT;
          end
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.data_data_ok) begin
          complete_s = 1'b1;
          busy       = busy_done_s;
          state_s    = done_next_s;
        end else begin
          state_s    = WAIT;
        end
      end
      DONE: begin
        if (!m_stall) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Load result to the pipeline.
  always_comb begin
`ifdef DMEM_RDATA_BYPASS_EN
    if (complete_s) begin
      m_rdata = bus.data_rdata;
    end else begin
      m_rdata = rdata_q;
    end
`else
    m_rdata = rdata_q;
`endif
  end

  // State, captured request and load-result registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        wr_r    <= m_wr;
        size_r  <= m_size;
        addr_r  <= m_addr;
        wdata_r <= m_wdata;
      end
      if (complete_s && !wr_r) begin
        rdata_q <= bus.data_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Table-driven bench for dmem_req_ctrl: cycle-by-cycle vectors plus hand-written reset
// and bounded-wait sequences; expectations follow the DMEM_RDATA_BYPASS_EN setting.
module tb_dmem_req_ctrl;

`ifdef DMEM_RDATA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic CB = ~BYP;

  logic        clk;
  logic        resetn;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_cancel;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        busy;

  int tests;
  int failed;

  dmem_req_ctrl_if bus_if ();

  dmem_req_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_size   (m_size),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_cancel (m_cancel),
    .m_stall  (m_stall),
    .m_rdata  (m_rdata),
    .busy     (busy),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rq;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        cn;
    logic        st;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_busy;
    logic        e_req;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_mrdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic rq, logic wr, logic [1:0] sz, logic [31:0] ad,
                              logic [31:0] wd, logic cn, logic st, logic aok, logic dok,
                              logic [31:0] rd, logic eb, logic er, logic ewr, logic [1:0] esz,
                              logic [31:0] ead, logic [31:0] ewd, logic [31:0] emr);
    vec_t v;
    v.name = n; v.rq = rq; v.wr = wr; v.sz = sz; v.ad = ad; v.wd = wd; v.cn = cn; v.st = st;
    v.aok = aok; v.dok = dok; v.rd = rd; v.e_busy = eb; v.e_req = er; v.e_wr = ewr;
    v.e_size = esz; v.e_addr = ead; v.e_wdata = ewd; v.e_mrdata = emr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rq, logic wr, logic [1:0] sz, logic [31:0] ad, logic [31:0] wd,
                       logic cn, logic st, logic aok, logic dok, logic [31:0] rd);
    m_req = rq; m_wr = wr; m_size = sz; m_addr = ad; m_wdata = wd;
    m_cancel = cn; m_stall = st;
    bus_if.data_addr_ok = aok; bus_if.data_data_ok = dok; bus_if.data_rdata = rd;
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    drive(v.rq, v.wr, v.sz, v.ad, v.wd, v.cn, v.st, v.aok, v.dok, v.rd);
    #1;
    chk({v.name, ".busy"}, {31'd0, busy}, {31'd0, v.e_busy});
    chk({v.name, ".data_req"}, {31'd0, bus_if.data_req}, {31'd0, v.e_req});
    chk({v.name, ".m_rdata"}, m_rdata, v.e_mrdata);
    if (v.e_req) begin
      chk({v.name, ".data_wr"}, {31'd0, bus_if.data_wr}, {31'd0, v.e_wr});
      chk({v.name, ".data_size"}, {30'd0, bus_if.data_size}, {30'd0, v.e_size});
      chk({v.name, ".data_addr"}, bus_if.data_addr, v.e_addr);
      chk({v.name, ".data_wdata"}, bus_if.data_wdata, v.e_wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    tests  = 0;
    failed = 0;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Word load at 0x1000: addr_ok in cycle 1, data_ok in cycle 3.
    vq.push_back(mk("ld_accept",  1'b1,1'b0,2'd2,32'h1000,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0));
    vq.push_back(mk("ld_req",     1'b1,1'b1,2'd0,32'hFFFF_FFFC,32'h7777_7777,1'b0,1'b0,1'b1,1'b0,32'h0,
                    1'b1,1'b1,1'b0,2'd2,32'h1000,32'h0,32'h0));
    vq.push_back(mk("ld_wait",    1'b1,1'b0,2'd2,32'h1000,32'h0,1'b0,1'b0,1'b1,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0));
    vq.push_back(mk("ld_cmpl",    1'b1,1'b0,2'd2,32'h1000,32'h0,1'b0,1'b0,1'b0,1'b1,32'hDEAD_BEEF,
                    CB,1'b0,1'b0,2'd0,32'h0,32'h0,BYP ? 32'hDEAD_BEEF : 32'h0));
    vq.push_back(mk("ld_release", 1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("idle_stray", 1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b1,1'b1,32'h1234_5678,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("idle_hold",  1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    // Cancelled request in IDLE is never accepted.
    vq.push_back(mk("cancel_idle",  1'b1,1'b0,2'd2,32'h8000,32'h0,1'b1,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("cancel_idle2", 1'b1,1'b1,2'd0,32'h8001,32'h0,1'b1,1'b0,1'b1,1'b1,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("cancel_after", 1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    // Byte store 0xAB at 0x2003 with addr_ok low for five cycles.
    vq.push_back(mk("st_accept",  1'b1,1'b1,2'd0,32'h2003,32'h0000_00AB,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    for (int i = 0; i < 5; i++) begin
      vq.push_back(mk($sformatf("st_hold%0d", i), 1'b1,1'b0,2'd2,32'h5555_0000 + 32'(i),32'hFFFF_FFFF,
                      (i == 2) ? 1'b1 : 1'b0,1'b0,1'b0,(i == 3) ? 1'b1 : 1'b0,32'h0,
                      1'b1,1'b1,1'b1,2'd0,32'h2003,32'h0000_00AB,32'hDEAD_BEEF));
    end
    vq.push_back(mk("st_addr_ok", 1'b1,1'b0,2'd2,32'h5555_0000,32'hFFFF_FFFF,1'b0,1'b0,1'b1,1'b0,32'h0,
                    1'b1,1'b1,1'b1,2'd0,32'h2003,32'h0000_00AB,32'hDEAD_BEEF));
    vq.push_back(mk("st_wait_cn", 1'b1,1'b0,2'd2,32'h0,32'h0,1'b1,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("st_cmpl",    1'b1,1'b0,2'd2,32'h0,32'h0,1'b1,1'b0,1'b0,1'b1,32'hCAFE_F00D,
                    CB,1'b0,1'b0,2'd0,32'h0,32'h0,BYP ? 32'hCAFE_F00D : 32'hDEAD_BEEF));
    vq.push_back(mk("st_release", 1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("st_idle",    1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    // Half load where addr_ok and data_ok arrive together in the first REQ cycle.
    vq.push_back(mk("ldh_accept", 1'b1,1'b0,2'd1,32'h3002,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'hDEAD_BEEF));
    vq.push_back(mk("ldh_same",   1'b1,1'b0,2'd1,32'h3002,32'h0,1'b0,1'b0,1'b1,1'b1,32'h0000_BEEF,
                    CB,1'b1,1'b0,2'd1,32'h3002,32'h0,BYP ? 32'h0000_BEEF : 32'hDEAD_BEEF));
    vq.push_back(mk("ldh_release",1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0000_BEEF));
    vq.push_back(mk("ldh_idle",   1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0000_BEEF));
    // Load completing under a three-cycle stall; DONE must not accept the held m_req.
    vq.push_back(mk("stl_accept", 1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'h0000_BEEF));
    vq.push_back(mk("stl_req",    1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b0,1'b1,1'b0,32'h0,
                    1'b1,1'b1,1'b0,2'd2,32'h4000,32'h0,32'h0000_BEEF));
    vq.push_back(mk("stl_cmpl",   1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b1,1'b0,1'b1,32'h1122_3344,
                    CB,1'b0,1'b0,2'd0,32'h0,32'h0,BYP ? 32'h1122_3344 : 32'h0000_BEEF));
    vq.push_back(mk("stl_stall2", 1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b1,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h1122_3344));
    vq.push_back(mk("stl_stall3", 1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b1,1'b0,1'b1,32'h5555_5555,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h1122_3344));
    vq.push_back(mk("stl_unstall",1'b1,1'b0,2'd2,32'h4000,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h1122_3344));
    vq.push_back(mk("stl_idle",   1'b0,1'b0,2'd0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,2'd0,32'h0,32'h0,32'h1122_3344));
    // Lead-in to the reset-in-WAIT sequence.
    vq.push_back(mk("rst_accept", 1'b1,1'b0,2'd2,32'h5000,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,
                    1'b1,1'b0,1'b0,2'd0,32'h0,32'h0,32'h1122_3344));
    vq.push_back(mk("rst_req",    1'b1,1'b0,2'd2,32'h5000,32'h0,1'b0,1'b0,1'b1,1'b0,32'h0,
                    1'b1,1'b1,1'b0,2'd2,32'h5000,32'h0,32'h1122_3344));

    // Reset state, including the combinational busy term while reset is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.data_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("reset.m_rdata", m_rdata, 32'd0);
    m_req = 1'b1;
    #1;
    chk("reset.busy_comb", {31'd0, busy}, 32'd1);
    chk("reset.data_req_comb", {31'd0, bus_if.data_req}, 32'd0);
    m_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    // Reset pulsed in WAIT abandons the transaction; a later stray data_ok is ignored.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'h5000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("wait.busy", {31'd0, busy}, 32'd1);
    chk("wait.data_req", {31'd0, bus_if.data_req}, 32'd0);
    #1;
    m_req  = 1'b0;
    resetn = 1'b0;
    #1;
    chk("wrst.busy", {31'd0, busy}, 32'd0);
    chk("wrst.data_req", {31'd0, bus_if.data_req}, 32'd0);
    chk("wrst.m_rdata", m_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9999_9999);
    #1;
    chk("stray.busy", {31'd0, busy}, 32'd0);
    chk("stray.data_req", {31'd0, bus_if.data_req}, 32'd0);
    @(negedge clk);
    bus_if.data_data_ok = 1'b0;
    #1;
    chk("stray.m_rdata", m_rdata, 32'd0);
    chk("stray.data_req2", {31'd0, bus_if.data_req}, 32'd0);

    // Fresh load after reset, with a bounded wait for the bus request.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'h6000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = bus_if.data_req;
    end
    chk("fresh.req_seen", {31'd0, seen}, 32'd1);
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hA5A5_5A5A;
    chk("fresh.data_addr", bus_if.data_addr, 32'h6000);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("fresh.m_rdata", m_rdata, 32'hA5A5_5A5A);
    chk("fresh.busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
REQ-002 The CPU-side ports SHALL be as follows.
- m_req  in  1  memory-stage access request
- m_wr  in  1  1 = store
- m_size  in  2  0 = byte, 1 = half, 2 = word
- m_addr  in  32  byte address
- m_wdata  in  32  store data
- m_cancel  in  1  memory-stage exception; suppresses a new access
- m_stall  in  1  memory stage held by another source
- m_rdata  out  32  load result to pipeline
- busy  out  1  stall request to hazard unit
REQ-003 The SRAM-like bus ports SHALL be as follows.
- data_req  out  1
- data_wr  out  1
- data_size  out  2
- data_addr  out  32
- data_wdata  out  32
- data_addr_ok  in  1
- data_data_ok  in  1
- data_rdata  in  32

Function
REQ-004 The block SHALL implement four states: IDLE, REQ, WAIT, DONE.
REQ-005 Accept condition: IDLE and m_req=1 and m_cancel=0; the block SHALL capture m_wr/m_size/m_addr/m_wdata into registers and go to REQ.
REQ-006 In REQ: data_req=1 and the bus fields SHALL be driven from the captured registers, never from the m_* inputs.
REQ-007 REQ transitions:
- addr_ok=1 and data_ok=0 -> WAIT.
- addr_ok=1 and data_ok=1 in the same cycle -> completion.
- addr_ok=0 -> stay in REQ with all fields stable.
REQ-008 In WAIT: data_req=0; data_ok=1 SHALL be completion.
REQ-009 On completion, the block SHALL register data_rdata into rdata_q for loads; for stores, rdata_q is unchanged.
REQ-010 DONE: busy=0 and m_rdata=rdata_q; the block SHALL leave DONE for IDLE in the first cycle m_stall=0.
REQ-011 busy SHALL be 1 when either holds:
- IDLE and accept condition true (combinational);
- state is REQ or WAIT, except as relaxed by REQ-016.
REQ-012 m_cancel SHALL be ignored after acceptance; the transaction runs to completion and the pipeline discards the result.
REQ-013 A data_ok seen in IDLE or DONE SHALL be ignored; a data_addr_ok seen outside REQ SHALL be ignored.
REQ-014 At most one transaction SHALL be outstanding; no new acceptance SHALL occur in REQ, WAIT or DONE.

Reset
REQ-015 On resetn=0, asynchronously: state=IDLE, data_req=0, rdata_q=0, captured registers=0, busy driven only by the combinational term of REQ-011; resetn asserted mid-transaction SHALL abandon it without further bus activity.

Configuration
REQ-016 Macro DMEM_RDATA_BYPASS_EN:
- Defined: in the completion cycle busy=0 and m_rdata=data_rdata combinationally; the next state is IDLE if m_stall=0, else DONE.
- Undefined: completion always goes to DONE with busy=1 in the completion cycle; load-to-release latency is one cycle longer.

Verification
REQ-017 Word load at 0x1000, addr_ok in cycle 1, data_ok in cycle 3 with data_rdata=0xDEADBEEF -> m_rdata=0xDEADBEEF; busy drops in cycle 3 (bypass) or cycle 4 (no bypass).
REQ-018 Store of byte 0xAB at 0x2003, addr_ok held low for 5 cycles -> data_addr=0x2003, data_size=0, data_wr=1 stable throughout; exactly one accepted request.
REQ-019 addr_ok and data_ok high together in the first REQ cycle -> completion with no WAIT; data_req high for exactly one cycle.
REQ-020 m_req=1 with m_cancel=1 in IDLE -> data_req stays 0, busy=0; m_cancel=1 asserted in WAIT -> transaction still completes.
REQ-021 Load completes while m_stall=1 for 3 cycles -> state DONE, m_rdata held, no second request; IDLE one cycle after m_stall falls.
REQ-022 resetn pulsed low in WAIT -> data_req=0, state IDLE immediately; a later stray data_ok is ignored.
